// File: rtl/tile_fb_pkg.sv
// Shared constants and state encoding for the tile framebuffer controller
// and the VGA timing block that reads the same framebuffer geometry.
package tile_fb_pkg;

   localparam int COLS   = 40;
   localparam int ROWS   = 30;
   localparam int CELLS  = COLS * ROWS;
   localparam int ADDR_W = 11;
   localparam int ROW_W  = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      HOLD  = 2'd2,
      CLEAR = 2'd3
   } fb_state_t;

endpackage

// File: rtl/tile_fb_ctrl_if.sv
// Write-request handshake for the two framebuffer requesters A and B.
// Requesters hold req with a stable addr/val until they see their ack pulse.
interface tile_fb_ctrl_if;
   import tile_fb_pkg::*;

   logic              req_a;
   logic [ADDR_W-1:0] addr_a;
   logic              val_a;
   logic              ack_a;

   logic              req_b;
   logic [ADDR_W-1:0] addr_b;
   logic              val_b;
   logic              ack_b;

   modport master (
      output req_a, addr_a, val_a,
      output req_b, addr_b, val_b,
      input  ack_a, ack_b
   );

   modport slave (
      input  req_a, addr_a, val_a,
      input  req_b, addr_b, val_b,
      output ack_a, ack_b
   );

endinterface

// File: rtl/tile_fb_ctrl_rr_arb2.sv
// Two-input round-robin arbiter. The grant is combinational from the
// current requests; the priority pointer only moves when the owner
// actually commits a grant (advance), so idle cycles do not shift fairness.
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   input  logic advance,
   output logic grant_a,
   output logic grant_b
);

   logic prio_b;

   // Pick the requester that was not served last when both are asking.
   always_comb begin
      grant_a = req_a & (~req_b | ~prio_b);
      grant_b = req_b & (~req_a | prio_b);
   end

   // After a committed grant, hand priority to the other requester.
   always_ff @(posedge clk) begin
      if (rst) begin
         prio_b <= 1'b0;
      end else if (advance) begin
         if (grant_a) begin
            prio_b <= 1'b1;
         end else if (grant_b) begin
            prio_b <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/tile_fb_ctrl.sv
// Tile framebuffer controller: serialises single-bit writes from two
// requesters into a 1-bit-per-tile framebuffer and performs row-by-row
// clears, touching the framebuffer only during vertical blanking.
module tile_fb_ctrl
   import tile_fb_pkg::*;
#(
   parameter int COLS = tile_fb_pkg::COLS,
   parameter int ROWS = tile_fb_pkg::ROWS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vblank,
   tile_fb_ctrl_if.slave         bus,
   input  logic                  clear_req,
   output logic                  clear_busy,
   output logic                  addr_err,
   output logic [COLS*ROWS-1:0]  fb_data
);

   localparam int CELLS = COLS * ROWS;
   localparam logic [CELLS-1:0] ROW_ONES = {{(CELLS-COLS){1'b0}}, {COLS{1'b1}}};

   fb_state_t         state;
   fb_state_t         state_nxt;
   logic              clear_pending;
   logic [ROW_W-1:0]  row_cnt;
   logic [CELLS-1:0]  fb_q;
   logic              ack_a_q;
   logic              ack_b_q;
   logic              addr_err_q;

   logic              grant_a;
   logic              grant_b;
   logic              wr_en;
   logic              addr_ok;
   logic              clear_row;
   logic              last_row;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_val;
   logic [CELLS-1:0]  clr_mask;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req_a   (bus.req_a),
      .req_b   (bus.req_b),
      .advance (wr_en),
      .grant_a (grant_a),
      .grant_b (grant_b)
   );

   // Next-state logic plus the per-cycle write/clear strobes. Clear wins
   // over writes, and WRITE completes regardless of vblank because the
   // grant was decided while vblank was still high.
   always_comb begin
      state_nxt = state;
      sel_addr  = grant_b ? bus.addr_b : bus.addr_a;
      sel_val   = grant_b ? bus.val_b  : bus.val_a;
      addr_ok   = (sel_addr < ADDR_W'(CELLS));
      wr_en     = (state == WRITE) && (grant_a || grant_b);
      clear_row = (state == CLEAR) && vblank;
      last_row  = (row_cnt == ROW_W'(ROWS - 1));
      clr_mask  = ROW_ONES << (int'(row_cnt) * COLS);

      case (state)
         IDLE: begin
            if (vblank && clear_pending) begin
               state_nxt = CLEAR;
            end else if (vblank && (bus.req_a || bus.req_b)) begin
               state_nxt = WRITE;
            end
         end
         WRITE: state_nxt = HOLD;
         HOLD:  state_nxt = IDLE;
         CLEAR: begin
            if (clear_row && last_row) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Handshake pulses, clear bookkeeping and the clear row counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_a_q       <= 1'b0;
         ack_b_q       <= 1'b0;
         addr_err_q    <= 1'b0;
         clear_pending <= 1'b0;
         row_cnt       <= '0;
      end else begin
         ack_a_q    <= wr_en && grant_a;
         ack_b_q    <= wr_en && grant_b;
         addr_err_q <= wr_en && !addr_ok;
         if (clear_req && !clear_pending) begin
            clear_pending <= 1'b1;
         end
         if (clear_row) begin
            if (last_row) begin
               row_cnt       <= '0;
               clear_pending <= 1'b0;
            end else begin
               row_cnt <= row_cnt + ROW_W'(1);
            end
         end
      end
   end

   // Framebuffer storage: zero one row per blanking cycle during a clear,
   // otherwise commit the granted bit if its address is in range.
   always_ff @(posedge clk) begin
      if (rst) begin
         fb_q <= '0;
      end else if (clear_row) begin
         fb_q <= fb_q & ~clr_mask;
      end else if (wr_en && addr_ok) begin
         fb_q[sel_addr] <= sel_val;
      end
   end

   assign bus.ack_a  = ack_a_q;
   assign bus.ack_b  = ack_b_q;
   assign addr_err   = addr_err_q;
   assign clear_busy = clear_pending;
   assign fb_data    = fb_q;

endmodule

// File: tb/tb_tile_fb_ctrl.sv
// Directed bench for tile_fb_ctrl: write latency, round robin, vblank
// gating, out-of-range addresses, paused clears and reset during a clear.
module tb_tile_fb_ctrl;
   import tile_fb_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              vblank = 1'b0;
   logic              clear_req = 1'b0;
   logic              clear_busy;
   logic              addr_err;
   logic [CELLS-1:0]  fb_data;
   logic [CELLS-1:0]  exp_fb;

   int checks = 0;
   int errors = 0;

   tile_fb_ctrl_if bus ();

   tile_fb_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .vblank     (vblank),
      .bus        (bus),
      .clear_req  (clear_req),
      .clear_busy (clear_busy),
      .addr_err   (addr_err),
      .fb_data    (fb_data)
   );

   // 50 MHz clock.
   always #10 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic ra, input logic [10:0] aa, input logic va,
                                input logic rb, input logic [10:0] ab, input logic vb);
      bus.req_a  = ra;
      bus.addr_a = aa;
      bus.val_a  = va;
      bus.req_b  = rb;
      bus.addr_b = ab;
      bus.val_b  = vb;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkFb(input string tag);
      checks++;
      assert (fb_data === exp_fb) else begin
         errors++;
         $error("[TB] FAIL %s: fb_data ones=%0d (bit0=%0b bit1199=%0b) expected ones=%0d (bit0=%0b bit1199=%0b)",
                tag, $countones(fb_data), fb_data[0], fb_data[CELLS-1],
                $countones(exp_fb), exp_fb[0], exp_fb[CELLS-1]);
      end
   endtask

   // Requester A write with a bounded wait for its ack; ends back in IDLE.
   task automatic writeA(input logic [10:0] addr, input logic val);
      logic got;
      got = 1'b0;
      applyStimulus(1'b1, addr, val, 1'b0, 11'd0, 1'b0);
      for (int i = 0; i < 10 && !got; i++) begin
         tick();
         got = bus.ack_a;
      end
      checkOutput("writeA_ack", 32'(got), 32'd1);
      bus.req_a = 1'b0;
      tick();
   endtask

   initial begin
      logic ack_seen;
      applyStimulus(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 1'b0);
      exp_fb = '0;

      // Reset state
      rst = 1'b1;
      tick(2);
      checkOutput("rst_ack_a", 32'(bus.ack_a), 32'd0);
      checkOutput("rst_ack_b", 32'(bus.ack_b), 32'd0);
      checkOutput("rst_addr_err", 32'(addr_err), 32'd0);
      checkOutput("rst_clear_busy", 32'(clear_busy), 32'd0);
      checkFb("rst_fb");
      rst = 1'b0;

      // Single write: ack exactly two cycles after the request
      vblank = 1'b1;
      applyStimulus(1'b1, 11'd0, 1'b1, 1'b0, 11'd0, 1'b0);
      tick();
      checkOutput("lat_ack_early", 32'(bus.ack_a), 32'd0);
      tick();
      exp_fb[0] = 1'b1;
      checkOutput("lat_ack_a", 32'(bus.ack_a), 32'd1);
      checkOutput("lat_addr_err", 32'(addr_err), 32'd0);
      checkFb("lat_fb");
      bus.req_a = 1'b0;
      tick();
      checkOutput("lat_ack_drop", 32'(bus.ack_a), 32'd0);

      // Simultaneous requests after reset: A first, B three cycles later
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_fb = '0;
      applyStimulus(1'b1, 11'd5, 1'b1, 1'b1, 11'd6, 1'b1);
      tick(2);
      checkOutput("rr_first_a", 32'({bus.ack_a, bus.ack_b}), 32'b10);
      bus.req_a = 1'b0;
      tick();
      checkOutput("rr_hold_quiet", 32'({bus.ack_a, bus.ack_b}), 32'b00);
      tick();
      checkOutput("rr_b_early", 32'(bus.ack_b), 32'd0);
      tick();
      checkOutput("rr_second_b", 32'({bus.ack_a, bus.ack_b}), 32'b01);
      exp_fb[6:5] = 2'b11;
      checkFb("rr_fb");
      bus.req_b = 1'b0;
      tick();

      // Requests wait out a visible interval
      vblank = 1'b0;
      applyStimulus(1'b0, 11'd0, 1'b0, 1'b1, 11'd1199, 1'b1);
      ack_seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.ack_b) ack_seen = 1'b1;
      end
      checkOutput("vb0_no_ack", 32'(ack_seen), 32'd0);
      checkFb("vb0_fb_same");
      vblank = 1'b1;
      tick();
      checkOutput("vb1_ack_early", 32'(bus.ack_b), 32'd0);
      tick();
      checkOutput("vb1_ack_b", 32'(bus.ack_b), 32'd1);
      exp_fb[1199] = 1'b1;
      checkFb("vb1_fb_1199");
      bus.req_b = 1'b0;
      tick();

      // Out-of-range address still acks, with addr_err, no fb change
      applyStimulus(1'b1, 11'd1200, 1'b1, 1'b0, 11'd0, 1'b0);
      tick(2);
      checkOutput("oor_ack_err", 32'({bus.ack_a, addr_err}), 32'b11);
      checkFb("oor_fb_same");
      bus.req_a = 1'b0;
      tick();
      checkOutput("oor_err_drop", 32'(addr_err), 32'd0);

      // Fill the whole framebuffer with ones
      for (int n = 0; n < CELLS; n++) begin
         writeA(11'(n), 1'b1);
      end
      exp_fb = '1;
      checkFb("fill_fb");

      // Clear with a 50-cycle pause in the middle; B waits throughout
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      checkOutput("clr_busy_rise", 32'(clear_busy), 32'd1);
      tick(11);
      for (int i = 0; i < 10 * COLS; i++) exp_fb[i] = 1'b0;
      checkFb("clr_rows0_9");
      vblank = 1'b0;
      applyStimulus(1'b0, 11'd0, 1'b0, 1'b1, 11'd7, 1'b1);
      ack_seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (bus.ack_b) ack_seen = 1'b1;
      end
      checkOutput("clr_pause_busy", 32'(clear_busy), 32'd1);
      checkFb("clr_pause_fb");
      vblank = 1'b1;
      for (int i = 0; i < 19; i++) begin
         tick();
         if (bus.ack_b) ack_seen = 1'b1;
      end
      for (int i = 10 * COLS; i < 29 * COLS; i++) exp_fb[i] = 1'b0;
      checkOutput("clr_busy_row28", 32'(clear_busy), 32'd1);
      checkFb("clr_rows_to_28");
      tick();
      exp_fb = '0;
      checkOutput("clr_busy_fall", 32'(clear_busy), 32'd0);
      checkFb("clr_done_fb");
      checkOutput("clr_no_ack_b", 32'(ack_seen | bus.ack_b), 32'd0);
      tick(2);
      checkOutput("clr_then_ack_b", 32'(bus.ack_b), 32'd1);
      exp_fb[7] = 1'b1;
      checkFb("clr_then_fb7");
      bus.req_b = 1'b0;
      tick();

      // Reset in the middle of a clear (row counter at 12)
      writeA(11'd1199, 1'b1);
      exp_fb[1199] = 1'b1;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      applyStimulus(1'b1, 11'd500, 1'b1, 1'b0, 11'd0, 1'b0);
      tick(13);
      for (int i = 0; i < 12 * COLS; i++) exp_fb[i] = 1'b0;
      checkFb("rc_rows0_11");
      checkOutput("rc_no_ack", 32'(bus.ack_a), 32'd0);
      rst = 1'b1;
      tick();
      exp_fb = '0;
      checkFb("rc_fb_zero");
      checkOutput("rc_busy_low", 32'(clear_busy), 32'd0);
      checkOutput("rc_ack_low", 32'(bus.ack_a), 32'd0);
      rst = 1'b0;
      tick(2);
      checkOutput("rc_retry_ack", 32'(bus.ack_a), 32'd1);
      exp_fb[500] = 1'b1;
      checkFb("rc_retry_fb");
      bus.req_a = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
